// File: rtl/memc_host_if.sv
// CPU-side bridge into the memory controller request port.
// Holds one read or write at a time, strobes memc for a single cycle and
// returns read data a fixed number of edges after the read strobe. A read
// interrupted by memc going busy is dropped and reissued to the same address.
module memc_host_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  memc_clk,
  input  logic                  memc_reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic                  cpu_rdy,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_rd_valid,
  input  logic                  memc_busy,
  output logic                  memc_rd_enable,
  output logic                  memc_wr_enable,
  output logic [ADDR_WIDTH-1:0] memc_addr,
  output logic [DATA_WIDTH-1:0] memc_wr_data,
  input  logic [DATA_WIDTH-1:0] memc_rd_data,
  output logic [7:0]            retry_cnt
);

  typedef enum logic [1:0] {
    StBoot,
    StIdle,
    StIssue,
    StRdWait
  } state_e;

  localparam logic [3:0] RdLatency = 4'(RD_LATENCY);

  state_e     state;
  logic       we_q;
  logic [3:0] lat_cnt;

  // Single FSM; every output is a register updated here.
  always_ff @(posedge memc_clk or negedge memc_reset) begin
    if (!memc_reset) begin
      state          <= StBoot;
      we_q           <= 1'b0;
      lat_cnt        <= '0;
      cpu_rdy        <= 1'b0;
      cpu_rd_data    <= '0;
      cpu_rd_valid   <= 1'b0;
      memc_rd_enable <= 1'b0;
      memc_wr_enable <= 1'b0;
      memc_addr      <= '0;
      memc_wr_data   <= '0;
      retry_cnt      <= '0;
    end else begin
      // Strobes and the valid flag are single-cycle pulses by default.
      memc_rd_enable <= 1'b0;
      memc_wr_enable <= 1'b0;
      cpu_rd_valid   <= 1'b0;

      unique case (state)
        StBoot: begin
          if (!memc_busy) begin
            cpu_rdy <= 1'b1;
            state   <= StIdle;
          end
        end

        StIdle: begin
          // Accepted regardless of memc_busy; ISSUE waits it out.
          if (cpu_req) begin
            we_q         <= cpu_we;
            memc_addr    <= cpu_addr;
            memc_wr_data <= cpu_wr_data;
            cpu_rdy      <= 1'b0;
            state        <= StIssue;
          end
        end

        StIssue: begin
          if (memc_wr_enable) begin
            // Write strobe already issued last edge: retire the write.
            cpu_rdy <= 1'b1;
            state   <= StIdle;
          end else if (!memc_busy) begin
            if (we_q) begin
              memc_wr_enable <= 1'b1;
            end else begin
              memc_rd_enable <= 1'b1;
              lat_cnt        <= RdLatency;
              state          <= StRdWait;
            end
          end
        end

        StRdWait: begin
          if (memc_busy) begin
            // memc was reset mid-read; the data would be garbage, so retry.
            lat_cnt <= '0;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
            state   <= StIssue;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
              cpu_rd_data  <= memc_rd_data;
              cpu_rd_valid <= 1'b1;
              cpu_rdy      <= 1'b1;
              state        <= StIdle;
            end
          end
        end

        default: state <= StBoot;
      endcase
    end
  end

endmodule

// File: doc/memc_host_if.md
Name: memc_host_if

Overview:
- Upstream neighbour of the memory controller (memc). Sits between the 6502 core's memory bus and memc's request port.
- Accepts one CPU read or write at a time and holds the CPU off (cpu_rdy low) until memc is free.
- Issues single-cycle memc_rd_enable/memc_wr_enable pulses and returns read data after a fixed latency.
- Reissues a read that is interrupted by memc going busy (memc reset/BIST mid-read).

Parameters:
DATA_WIDTH, 8, data bus width
ADDR_WIDTH, 16, address bus width
RD_LATENCY, 2, rising edges from the edge that asserts memc_rd_enable to the edge that samples memc_rd_data; legal range 1..15

Ports:
memc_clk  input  1  clock; all logic on the rising edge
memc_reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU request; accepted on an edge where cpu_req=1 and cpu_rdy=1
cpu_we  input  1  1=write, 0=read; sampled with cpu_req
cpu_addr  input  ADDR_WIDTH  request address; sampled with cpu_req
cpu_wr_data  input  DATA_WIDTH  write data; sampled with cpu_req
cpu_rdy  output  1  bridge idle and able to accept a request
cpu_rd_data  output  DATA_WIDTH  last read result; held until the next read completes
cpu_rd_valid  output  1  one-cycle pulse; cpu_rd_data updated this cycle
memc_busy  input  1  memc not ready (reset/BIST in progress)
memc_rd_enable  output  1  read strobe to memc
memc_wr_enable  output  1  write strobe to memc
memc_addr  output  ADDR_WIDTH  address to memc
memc_wr_data  output  DATA_WIDTH  write data to memc
memc_rd_data  input  DATA_WIDTH  read data from memc
retry_cnt  output  8  saturating count of aborted-and-reissued reads

Behaviour:
- All outputs are registered.
- Reset (memc_reset=0, asynchronous):
  - State goes to BOOT.
  - cpu_rdy, cpu_rd_valid, memc_rd_enable and memc_wr_enable are 0.
  - cpu_rd_data, memc_addr, memc_wr_data and retry_cnt are 0.
  - Internal request registers and the latency counter are cleared.
- States: BOOT, IDLE, ISSUE, RD_WAIT.
- BOOT:
  - cpu_rdy=0.
  - On the first edge with memc_busy=0: cpu_rdy<=1 and go to IDLE.
- IDLE:
  - cpu_rdy=1.
  - On an edge with cpu_req=1: capture cpu_we, cpu_addr and cpu_wr_data into memc_addr/memc_wr_data and an internal we bit; set cpu_rdy<=0; go to ISSUE.
  - The request is accepted even if memc_busy=1.
- ISSUE:
  - Edge with memc_busy=1: stay in ISSUE; strobes stay 0.
  - Edge with memc_busy=0 and we=1: memc_wr_enable<=1 for exactly one cycle, cleared on the next edge; cpu_rdy<=1 on that next edge; go to IDLE.
  - Write latency: accept at edge N, strobe high N+1..N+2, cpu_rdy high from N+2.
  - Edge with memc_busy=0 and we=0: memc_rd_enable<=1 for exactly one cycle; load the counter with RD_LATENCY; go to RD_WAIT.
- RD_WAIT:
  - Each edge decrements the counter.
  - On the edge where the counter reaches 0: cpu_rd_data<=memc_rd_data, cpu_rd_valid<=1 (one cycle), cpu_rdy<=1, go to IDLE.
  - Read latency: accept at N, strobe at N+1, data/valid/rdy at N+1+RD_LATENCY.
  - If memc_busy=1 on any RD_WAIT edge: discard the read, clear the counter, retry_cnt<=retry_cnt+1 (saturates at 255), go to ISSUE.
  - The read is reissued with the same captured address once memc_busy=0.
  - cpu_rd_data is not updated by an aborted read.
- memc_rd_enable and memc_wr_enable are never both 1. Each is never high for two consecutive cycles.
- memc_addr and memc_wr_data are stable from acceptance until the bridge returns to IDLE.
- cpu_req while cpu_rdy=0 is ignored; there is no queueing.
- Back-to-back requests: a new request may be accepted on the same edge that cpu_rdy is observed high (one idle cycle minimum between strobes).
- Reset mid-operation: asynchronous return to BOOT, the outstanding request is lost, and all outputs take their reset values immediately.

Test Plan:
- Reset release with memc_busy=1 for 20 cycles, then 0 -> cpu_rdy stays 0 through the busy period and rises on the first edge after memc_busy=0.
- Write addr 0x1234 data 0xA5 at edge N -> memc_wr_enable=1 for only cycle N+1, memc_addr=0x1234, memc_wr_data=0xA5, cpu_rdy=1 at N+2.
- Read addr 0x00FF with memc_rd_data=0x3C, RD_LATENCY=2 -> memc_rd_enable pulse at N+1, cpu_rd_valid pulse and cpu_rd_data=0x3C at N+3, cpu_rdy=1 at N+3.
- Read issued, memc_busy raised for 5 cycles at RD_WAIT edge 1 -> no cpu_rd_valid, retry_cnt=1, memc_rd_enable re-pulses to the same address after busy falls, data returned RD_LATENCY edges later.
- Request accepted while memc_busy=1 -> bridge waits in ISSUE with no strobe; the strobe occurs on the first edge with memc_busy=0.
- Assert memc_reset=0 mid-read -> all outputs zero immediately with no clock; after release the bridge is back in BOOT with cpu_rdy=0.
